clk_lock_seq: RTL and testbench
===============================

CLK_LOCK_SEQ -- requirements
Module: clk_lock_seq

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning number of downstream reset channels (1-8).
REQ-002 SHALL have parameter RST_PULSE_CYC, default 16, meaning MMCM reset pulse width in cycles (>=1).
REQ-003 SHALL have parameter LOCK_STABLE_CYC, default 1024, meaning consecutive locked cycles required before release (>=1).
REQ-004 SHALL have parameter LOCK_TIMEOUT_CYC, default 65536, meaning maximum cycles from MMCM reset release to stable lock (> LOCK_STABLE_CYC).
REQ-005 SHALL have parameter CH_GAP_CYC, default 8, meaning cycles between successive channel reset releases (>=1).
REQ-006 SHALL have port i_clk  input  1  free-running reference clock (MMCM input clock, not MMCM output).
REQ-007 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port i_mmcm_locked  input  1  MMCM LOCKED, asynchronous to i_clk.
REQ-009 SHALL have port i_restart  input  1  single-cycle request to restart the MMCM.
REQ-010 SHALL have port o_mmcm_rst  output  1  MMCM RST, active-high.
REQ-011 SHALL have port o_ch_rst  output  N_CH  per-channel reset, active-high, bit 0 released first.
REQ-012 SHALL have port o_ready  output  1  all channels out of reset, clock stable.
REQ-013 SHALL have port o_state  output  3  current state encoding.
REQ-014 SHALL have port o_relock_cnt  output  8  count of recovery restarts, saturating.

Function
REQ-015 SHALL synchronise i_mmcm_locked through two flops; "lock" below means the synchronised value (2-cycle latency).
REQ-016 SHALL implement states RESET_MMCM=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4; o_state equals the registered state.
REQ-017 RESET_MMCM: o_mmcm_rst=1 for exactly RST_PULSE_CYC cycles, all o_ch_rst=1, then WAIT_LOCK with o_mmcm_rst=0.
REQ-018 WAIT_LOCK: on lock=1 go STABLE; timeout counter starts at 0 on entry from RESET_MMCM only.
REQ-019 STABLE: after LOCK_STABLE_CYC consecutive cycles of lock=1 go RELEASE; lock=0 returns to WAIT_LOCK, stable counter cleared, timeout counter not cleared, o_relock_cnt unchanged.
REQ-020 Timeout counter SHALL run through WAIT_LOCK and STABLE; on reaching LOCK_TIMEOUT_CYC go RESET_MMCM and increment o_relock_cnt.
REQ-021 RELEASE: o_ch_rst[k] SHALL fall CH_GAP_CYC*(k+1) cycles after RELEASE entry; one cycle after o_ch_rst[N_CH-1] falls go RUN.
REQ-022 RUN: o_ready=1, all o_ch_rst=0; o_ready=0 in every other state.
REQ-023 lock=0 in RELEASE or RUN SHALL set all o_ch_rst=1 and o_ready=0 on the next edge, go RESET_MMCM, increment o_relock_cnt.
REQ-024 i_restart=1 in any state other than RESET_MMCM SHALL go RESET_MMCM, assert all o_ch_rst, increment o_relock_cnt; ignored in RESET_MMCM.
REQ-025 Simultaneous i_restart, lock loss and/or timeout SHALL cause one transition and a single increment.
REQ-026 o_relock_cnt SHALL saturate at 255; cleared only by i_rst.
REQ-027 Released channels SHALL never re-release out of order; any reassertion asserts all channels in the same cycle.
REQ-028 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-029 i_rst=1 SHALL asynchronously force: state RESET_MMCM, o_mmcm_rst=1, o_ch_rst all 1, o_ready=0, o_state=0, o_relock_cnt=0, all counters and synchroniser flops 0.
REQ-030 After i_rst deassertion the RST_PULSE_CYC pulse count SHALL start from 0 on the first edge; i_rst mid-operation aborts any state with the same values.

Verification (N_CH=3, RST_PULSE_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=32, CH_GAP_CYC=2)
REQ-031 Reset release, lock rises 10 cycles later and holds -> o_mmcm_rst high 4 cycles; STABLE entered 2 cycles after lock rise; o_ch_rst 3'b110,3'b100,3'b000 at 2/4/6 cycles after RELEASE entry; o_ready=1 one cycle later; o_relock_cnt=0.
REQ-032 Lock never asserts -> o_mmcm_rst repulses every 36 cycles (4+32); o_relock_cnt 1,2,3...; o_ch_rst stays 3'b111.
REQ-033 In RUN, drop lock one cycle -> 3 cycles later o_ch_rst=3'b111, o_ready=0, o_state=0, o_relock_cnt=1, then full sequence repeats.
REQ-034 Lock chatters (5 high/1 low) in STABLE -> never reaches RELEASE; timeout at 32 cycles after WAIT_LOCK entry from RESET_MMCM, o_relock_cnt increments.
REQ-035 i_restart and lock loss same cycle in RUN -> single RESET_MMCM entry, o_relock_cnt +1 only; i_restart during RESET_MMCM -> pulse width stays 4.
REQ-036 Force 300 restarts -> o_relock_cnt=255; assert i_rst mid-RELEASE -> all outputs at REQ-029 values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/clk_lock_seq.sv
// rtl/clk_lock_seq.sv - MMCM reset/lock sequencer with staged per-channel reset release
module clk_lock_seq #(
    parameter int N_CH             = 4,
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int CH_GAP_CYC       = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_mmcm_locked,
    input  logic            i_restart,
    output logic            o_mmcm_rst,
    output logic [N_CH-1:0] o_ch_rst,
    output logic            o_ready,
    output logic [2:0]      o_state,
    output logic [7:0]      o_relock_cnt
);

    typedef enum logic [2:0] {
        S_RESET_MMCM = 3'd0,
        S_WAIT_LOCK  = 3'd1,
        S_STABLE     = 3'd2,
        S_RELEASE    = 3'd3,
        S_RUN        = 3'd4
    } state_t;

    localparam logic [31:0] PULSE_LAST   = 32'(RST_PULSE_CYC - 1);
    localparam logic [31:0] STABLE_LAST  = 32'(LOCK_STABLE_CYC - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [31:0] RELEASE_DONE = 32'(CH_GAP_CYC * N_CH);

    state_t            state_q, state_d;
    logic              lock_meta_q, lock_q;
    logic [31:0]       cnt_q, cnt_d;
    logic [31:0]       to_cnt_q, to_cnt_d;
    logic              mmcm_rst_q, mmcm_rst_d;
    logic [N_CH-1:0]   ch_rst_q, ch_rst_d;
    logic              ready_q, ready_d;
    logic [7:0]        relock_q, relock_d;
    logic              abort;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lock_meta_q <= 1'b0;
            lock_q      <= 1'b0;
            state_q     <= S_RESET_MMCM;
            cnt_q       <= '0;
            to_cnt_q    <= '0;
            mmcm_rst_q  <= 1'b1;
            ch_rst_q    <= '1;
            ready_q     <= 1'b0;
            relock_q    <= '0;
        end else begin
            lock_meta_q <= i_mmcm_locked;
            lock_q      <= lock_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            to_cnt_q    <= to_cnt_d;
            mmcm_rst_q  <= mmcm_rst_d;
            ch_rst_q    <= ch_rst_d;
            ready_q     <= ready_d;
            relock_q    <= relock_d;
        end
    end

    // cnt_q is the per-state phase counter (pulse, stable run, release);
    // to_cnt_q spans WAIT_LOCK and STABLE so lock chatter cannot defeat the timeout.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        to_cnt_d   = to_cnt_q;
        mmcm_rst_d = mmcm_rst_q;
        ch_rst_d   = ch_rst_q;
        ready_d    = ready_q;
        relock_d   = relock_q;
        abort      = 1'b0;

        case (state_q)
            S_RESET_MMCM: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d    = S_WAIT_LOCK;
                    mmcm_rst_d = 1'b0;
                    cnt_d      = '0;
                    to_cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_WAIT_LOCK: begin
                if (to_cnt_q == TIMEOUT_LAST) begin
                    abort = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 32'd1;
                    if (lock_q) begin
                        state_d = S_STABLE;
                        cnt_d   = '0;
                    end
                end
            end
            S_STABLE: begin
                if (to_cnt_q == TIMEOUT_LAST) begin
                    abort = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 32'd1;
                    if (!lock_q) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = S_RELEASE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            S_RELEASE: begin
                if (!lock_q) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                    for (int k = 0; k < N_CH; k++) begin
                        if (cnt_q == 32'(CH_GAP_CYC * (k + 1) - 1)) begin
                            ch_rst_d[k] = 1'b0;
                        end
                    end
                    if (cnt_q == RELEASE_DONE) begin
                        state_d = S_RUN;
                        ready_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (!lock_q) begin
                    abort = 1'b1;
                end
            end
            default: begin
                abort = 1'b1;
            end
        endcase

        if (i_restart && (state_q != S_RESET_MMCM)) begin
            abort = 1'b1;
        end

        // Every recovery source funnels through here so coincident causes count once.
        if (abort) begin
            state_d    = S_RESET_MMCM;
            cnt_d      = '0;
            mmcm_rst_d = 1'b1;
            ch_rst_d   = '1;
            ready_d    = 1'b0;
            relock_d   = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
        end
    end

    assign o_mmcm_rst   = mmcm_rst_q;
    assign o_ch_rst     = ch_rst_q;
    assign o_ready      = ready_q;
    assign o_state      = state_q;
    assign o_relock_cnt = relock_q;

endmodule

// File: tb/tb_clk_lock_seq.sv
// tb/tb_clk_lock_seq.sv - self-checking bench for clk_lock_seq
module tb_clk_lock_seq;

    localparam int N_CH = 3;
    localparam int P    = 4;
    localparam int S    = 8;
    localparam int T    = 32;
    localparam int G    = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            locked;
    logic            restart;
    logic            mmcm_rst;
    logic [N_CH-1:0] ch_rst;
    logic            ready;
    logic [2:0]      state;
    logic [7:0]      relock;

    clk_lock_seq #(
        .N_CH(N_CH), .RST_PULSE_CYC(P), .LOCK_STABLE_CYC(S),
        .LOCK_TIMEOUT_CYC(T), .CH_GAP_CYC(G)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_mmcm_locked(locked), .i_restart(restart),
        .o_mmcm_rst(mmcm_rst), .o_ch_rst(ch_rst), .o_ready(ready),
        .o_state(state), .o_relock_cnt(relock)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       lock;
        logic       rs;
        int         n;
        logic [2:0] st;
        logic [2:0] ch;
        logic       mm;
        logic       rdy;
        logic [7:0] rc;
    } vec_t;

    typedef struct {
        logic [2:0] st;
        logic [2:0] ch;
        logic       mm;
        logic       rdy;
        logic [7:0] rc;
        string      tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_mmcm_rst"}, 32'(mmcm_rst), 32'd1);
        check({tag, "_ch_rst"}, 32'(ch_rst), 32'h7);
        check({tag, "_ready"}, 32'(ready), 32'd0);
        check({tag, "_relock"}, 32'(relock), 32'd0);
    endtask

    function automatic vec_t mkv(input logic lk, input logic rs, input int n, input logic [2:0] st,
                                 input logic [2:0] ch, input logic mm, input logic rdy, input logic [7:0] rc);
        vec_t v;
        v.lock = lk; v.rs = rs; v.n = n; v.st = st; v.ch = ch; v.mm = mm; v.rdy = rdy; v.rc = rc;
        return v;
    endfunction

    // Called at a negedge: drive inputs for the next edge, queue what that edge must produce.
    task automatic drive(input vec_t v, input string tag);
        exp_t x;
        locked  = v.lock;
        restart = v.rs;
        x.st = v.st; x.ch = v.ch; x.mm = v.mm; x.rdy = v.rdy; x.rc = v.rc; x.tag = tag;
        sbq.push_back(x);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check({e.tag, "_state"}, 32'(state), 32'(e.st));
            check({e.tag, "_ch_rst"}, 32'(ch_rst), 32'(e.ch));
            check({e.tag, "_mmcm_rst"}, 32'(mmcm_rst), 32'(e.mm));
            check({e.tag, "_ready"}, 32'(ready), 32'(e.rdy));
            check({e.tag, "_relock"}, 32'(relock), 32'(e.rc));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int edge_n, rises, highs, w_edge, to_edge, tmo, b, ph;
        int rise_at[3];
        logic [7:0] rc_at[3];
        logic prev_mm, ch_bad, saw_stable, saw_rel;

        rst = 1'b1; locked = 1'b0; restart = 1'b0;

        // Nominal bring-up, lock glitch in RUN, then restart coinciding with lock loss
        vecs.push_back(mkv(0, 0, 3, 0, 3'b111, 1, 0, 0));
        vecs.push_back(mkv(0, 0, 6, 1, 3'b111, 0, 0, 0));
        vecs.push_back(mkv(1, 0, 2, 1, 3'b111, 0, 0, 0));
        vecs.push_back(mkv(1, 0, 8, 2, 3'b111, 0, 0, 0));
        vecs.push_back(mkv(1, 0, 2, 3, 3'b111, 0, 0, 0));
        vecs.push_back(mkv(1, 0, 2, 3, 3'b110, 0, 0, 0));
        vecs.push_back(mkv(1, 0, 2, 3, 3'b100, 0, 0, 0));
        vecs.push_back(mkv(1, 0, 1, 3, 3'b000, 0, 0, 0));
        vecs.push_back(mkv(1, 0, 4, 4, 3'b000, 0, 1, 0));
        vecs.push_back(mkv(0, 0, 1, 4, 3'b000, 0, 1, 0));
        vecs.push_back(mkv(1, 0, 1, 4, 3'b000, 0, 1, 0));
        vecs.push_back(mkv(1, 0, 4, 0, 3'b111, 1, 0, 1));
        vecs.push_back(mkv(1, 0, 1, 1, 3'b111, 0, 0, 1));
        vecs.push_back(mkv(1, 0, 8, 2, 3'b111, 0, 0, 1));
        vecs.push_back(mkv(1, 0, 2, 3, 3'b111, 0, 0, 1));
        vecs.push_back(mkv(1, 0, 2, 3, 3'b110, 0, 0, 1));
        vecs.push_back(mkv(1, 0, 2, 3, 3'b100, 0, 0, 1));
        vecs.push_back(mkv(1, 0, 1, 3, 3'b000, 0, 0, 1));
        vecs.push_back(mkv(1, 0, 2, 4, 3'b000, 0, 1, 1));
        vecs.push_back(mkv(0, 0, 1, 4, 3'b000, 0, 1, 1));
        vecs.push_back(mkv(1, 0, 1, 4, 3'b000, 0, 1, 1));
        vecs.push_back(mkv(1, 1, 1, 0, 3'b111, 1, 0, 2));
        vecs.push_back(mkv(1, 1, 1, 0, 3'b111, 1, 0, 2));
        vecs.push_back(mkv(1, 0, 2, 0, 3'b111, 1, 0, 2));
        vecs.push_back(mkv(1, 0, 1, 1, 3'b111, 0, 0, 2));

        #12;
        check_reset_values("por");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            for (int j = 0; j < vecs[i].n; j++) begin
                drive(vecs[i], $sformatf("v%0d_%0d", i, j));
            end
        end
        restart = 1'b0;
        b = 0;
        while (sbq.size() > 0 && b < 10) begin
            @(negedge clk);
            b++;
        end
        check("sb_drained", 32'(sbq.size()), 32'd0);

        // Lock never arrives: repulse every P+T cycles
        rst = 1'b1; locked = 1'b0; restart = 1'b0;
        #1;
        check_reset_values("rst2");
        @(negedge clk);
        rst = 1'b0;
        edge_n = 0; rises = 0; highs = 0; prev_mm = 1'b1; ch_bad = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk);
            #1;
            edge_n++;
            if (mmcm_rst) highs++;
            if (mmcm_rst && !prev_mm && rises < 3) begin
                rise_at[rises] = edge_n;
                rc_at[rises]   = relock;
                rises++;
            end
            if (ch_rst != 3'b111) ch_bad = 1'b1;
            prev_mm = mmcm_rst;
        end
        check("nolock_rises", 32'(rises), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < rises) begin
                check($sformatf("nolock_rise%0d_edge", i), 32'(rise_at[i]), 32'(36 * (i + 1)));
                check($sformatf("nolock_rise%0d_relock", i), 32'(rc_at[i]), 32'(i + 1));
            end
        end
        check("nolock_high_cycles", 32'(highs), 32'd15);
        check("nolock_ch_held", 32'(ch_bad), 32'd0);

        // Lock chatters 5 high / 1 low: STABLE never completes, timeout wins
        @(negedge clk);
        rst = 1'b1; locked = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        edge_n = 0; w_edge = 0; to_edge = 0; ph = 0; saw_stable = 1'b0; saw_rel = 1'b0;
        for (int i = 0; i < 100 && to_edge == 0; i++) begin
            @(posedge clk);
            #1;
            edge_n++;
            if (state == 3'd1 && w_edge == 0) w_edge = edge_n;
            if (state == 3'd2) saw_stable = 1'b1;
            if (state == 3'd3) saw_rel = 1'b1;
            if (w_edge != 0 && state == 3'd0) to_edge = edge_n;
            if (w_edge != 0) begin
                locked = (ph % 6) != 5;
                ph++;
            end
        end
        check("chatter_timeout_edges", 32'(to_edge - w_edge), 32'd32);
        check("chatter_saw_stable", 32'(saw_stable), 32'd1);
        check("chatter_no_release", 32'(saw_rel), 32'd0);
        check("chatter_relock", 32'(relock), 32'd1);

        // 300 restarts: counter saturates
        locked = 1'b0;
        tmo = 0;
        for (int i = 0; i < 300; i++) begin
            b = 0;
            while (state == 3'd0 && b < 20) begin
                @(posedge clk);
                #1;
                b++;
            end
            if (state == 3'd0) tmo++;
            restart = 1'b1;
            @(posedge clk);
            #1;
            restart = 1'b0;
            if (i == 99) check("restart_relock_101", 32'(relock), 32'd101);
        end
        check("restart_waits", 32'(tmo), 32'd0);
        check("relock_saturated", 32'(relock), 32'd255);

        // Async reset mid-RELEASE takes effect without a clock edge
        locked = 1'b1;
        b = 0;
        while (ch_rst != 3'b110 && b < 80) begin
            @(posedge clk);
            #1;
            b++;
        end
        check("midrel_state", 32'(state), 32'd3);
        check("midrel_ch_rst", 32'(ch_rst), 32'h6);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async");
        #20;
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
